// File: rtl/board_if.sv
// Bus between the tic-tac-toe game logic and its surroundings: the
// synchronised mouse and new-game inputs, and the board and highlight
// state that drives the per-square overlay stages.
interface board_if;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        mouse_left;
    logic        new_game;
    logic [8:0]  square;
    logic [8:0]  occupied;
    logic [8:0]  owner;
    logic        turn;
    logic [1:0]  winner;
    logic        game_over;

    modport master (
        output xpos, ypos, mouse_left, new_game,
        input  square, occupied, owner, turn, winner, game_over
    );

    modport slave (
        input  xpos, ypos, mouse_left, new_game,
        output square, occupied, owner, turn, winner, game_over
    );
endinterface

// File: rtl/board_ctrl.sv
// Tic-tac-toe game logic in the pixel clock domain: maps the cursor to a
// 3x3 cell, registers moves on left-click edges, alternates X/O, and
// detects a win or a draw.
module board_ctrl #(
    parameter logic [11:0] H_END0 = 12'd340,
    parameter logic [11:0] H_BEG1 = 12'd344,
    parameter logic [11:0] H_END1 = 12'd679,
    parameter logic [11:0] H_BEG2 = 12'd683,
    parameter logic [11:0] V_END0 = 12'd255,
    parameter logic [11:0] V_BEG1 = 12'd259,
    parameter logic [11:0] V_END1 = 12'd507,
    parameter logic [11:0] V_BEG2 = 12'd511
) (
    input logic    pclk,
    input logic    rst,
    board_if.slave bus
);

    localparam logic [11:0] H_MAX = 12'd1023;
    localparam logic [11:0] V_MAX = 12'd767;

    // Cell masks of the eight winning lines: three rows, three columns, two diagonals.
    localparam logic [8:0] LINE_MASK [8] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

    state_t      state;
    logic [8:0]  square;
    logic [8:0]  occupied;
    logic [8:0]  owner;
    logic        turn;
    logic [1:0]  winner;
    logic        game_over;
    logic        btn_q;

    logic [1:0]  col;
    logic [1:0]  row;
    logic        col_ok;
    logic        row_ok;
    logic        cell_valid;
    logic [3:0]  cell_idx;
    logic        click;
    logic        win_now;

    // A line belongs to the given player when all three of its cells carry that player's mark.
    function automatic logic line_won(input logic [8:0] mask, input logic [8:0] occ,
                                      input logic [8:0] own, input logic who);
        return ((occ & mask) == mask) && ((own & mask) == (who ? mask : 9'h000));
    endfunction

    // Decode the cursor position into a cell; grid lines and off-screen positions are no cell.
    always_comb begin
        col    = 2'd0;
        col_ok = 1'b0;
        row    = 2'd0;
        row_ok = 1'b0;
        if (bus.xpos <= H_END0) begin
            col    = 2'd0;
            col_ok = 1'b1;
        end else if (bus.xpos >= H_BEG1 && bus.xpos <= H_END1) begin
            col    = 2'd1;
            col_ok = 1'b1;
        end else if (bus.xpos >= H_BEG2 && bus.xpos <= H_MAX) begin
            col    = 2'd2;
            col_ok = 1'b1;
        end
        if (bus.ypos <= V_END0) begin
            row    = 2'd0;
            row_ok = 1'b1;
        end else if (bus.ypos >= V_BEG1 && bus.ypos <= V_END1) begin
            row    = 2'd1;
            row_ok = 1'b1;
        end else if (bus.ypos >= V_BEG2 && bus.ypos <= V_MAX) begin
            row    = 2'd2;
            row_ok = 1'b1;
        end
        cell_valid = col_ok & row_ok;
        cell_idx   = {2'b00, row} * 4'd3 + {2'b00, col};
    end

    // The current mover wins when any of the eight lines is complete in their mark.
    always_comb begin
        win_now = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (line_won(LINE_MASK[i], occupied, owner, turn)) begin
                win_now = 1'b1;
            end
        end
    end

    assign click = bus.mouse_left & ~btn_q;

    // Remember the previous button level so a held button yields a single click.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= bus.mouse_left;
        end
    end

    // Hover highlight follows the cursor in every game state.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            square <= 9'h000;
        end else begin
            square <= cell_valid ? (9'h001 << cell_idx) : 9'h000;
        end
    end

    // Game FSM: accept a move, judge it for one cycle, then either hand over the turn or end the game.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state     <= PLAY;
            occupied  <= 9'h000;
            owner     <= 9'h000;
            turn      <= 1'b0;
            winner    <= 2'b00;
            game_over <= 1'b0;
        end else if (bus.new_game) begin
            state     <= PLAY;
            occupied  <= 9'h000;
            owner     <= 9'h000;
            turn      <= 1'b0;
            winner    <= 2'b00;
            game_over <= 1'b0;
        end else begin
            case (state)
                PLAY: begin
                    if (click && cell_valid && !occupied[cell_idx]) begin
                        occupied[cell_idx] <= 1'b1;
                        owner[cell_idx]    <= turn;
                        state              <= CHECK;
                    end
                end
                CHECK: begin
                    if (win_now) begin
                        winner    <= {turn, ~turn};
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else if (occupied == 9'h1FF) begin
                        winner    <= 2'b11;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        turn  <= ~turn;
                        state <= PLAY;
                    end
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= PLAY;
                end
            endcase
        end
    end

    assign bus.square    = square;
    assign bus.occupied  = occupied;
    assign bus.owner     = owner;
    assign bus.turn      = turn;
    assign bus.winner    = winner;
    assign bus.game_over = game_over;

endmodule

// File: tb/tb_board_ctrl.sv
// Self-checking bench for board_ctrl: table-driven per-cycle vectors whose
// expected outputs go through a scoreboard queue, plus hand-written
// sequences for held buttons, game restart and asynchronous reset.
module tb_board_ctrl;

    logic pclk = 1'b0;
    logic rst  = 1'b1;

    always #5 pclk = ~pclk;

    board_if bif();

    board_ctrl dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bif)
    );

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic        btn;
        logic        ng;
        logic [8:0]  sq;
        logic [8:0]  occ;
        logic [8:0]  own;
        logic        turn;
        logic [1:0]  win;
        logic        go;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    vec_t sb[$];
    vec_t tab_a[$];
    vec_t tab_b[$];

    function automatic vec_t mk(input int x, input int y, input int btn, input int ng,
                                input int sq, input int occ, input int own,
                                input int turn, input int win, input int go);
        vec_t v;
        v.x = 12'(x);   v.y = 12'(y);
        v.btn = 1'(btn); v.ng = 1'(ng);
        v.sq = 9'(sq);  v.occ = 9'(occ); v.own = 9'(own);
        v.turn = 1'(turn); v.win = 2'(win); v.go = 1'(go);
        return v;
    endfunction

    function automatic int cx(input int k);
        return (k % 3 == 0) ? 100 : (k % 3 == 1) ? 500 : 800;
    endfunction

    function automatic int cy(input int k);
        return (k / 3 == 0) ? 100 : (k / 3 == 1) ? 400 : 600;
    endfunction

    // Cursor parked on cell k (so the hover highlight is bit k).
    function automatic vec_t mv(input int k, input int btn, input int occ, input int own,
                                input int turn, input int win, input int go);
        return mk(cx(k), cy(k), btn, 0, 1 << k, occ, own, turn, win, go);
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t e);
        chk({tag, " square"},    bif.square,             e.sq);
        chk({tag, " occupied"},  bif.occupied,           e.occ);
        chk({tag, " owner"},     bif.owner,              e.own);
        chk({tag, " turn"},      {8'b0, bif.turn},       {8'b0, e.turn});
        chk({tag, " winner"},    {7'b0, bif.winner},     {7'b0, e.win});
        chk({tag, " game_over"}, {8'b0, bif.game_over},  {8'b0, e.go});
    endtask

    // Drive one cycle of inputs at the falling edge and judge the registered response one edge later.
    task automatic step(input string tag, input vec_t v);
        vec_t e;
        bif.xpos       = v.x;
        bif.ypos       = v.y;
        bif.mouse_left = v.btn;
        bif.new_game   = v.ng;
        sb.push_back(v);
        @(posedge pclk);
        @(negedge pclk);
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
        end else begin
            e = sb.pop_front();
            check_all(tag, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.xpos       = 12'd0;
        bif.ypos       = 12'd0;
        bif.mouse_left = 1'b0;
        bif.new_game   = 1'b0;

        // Hover decode and first X move.
        tab_a.push_back(mk(500, 400, 0, 0, 'h010, 0, 0, 0, 0, 0));
        tab_a.push_back(mk(342, 400, 0, 0, 'h000, 0, 0, 0, 0, 0));
        tab_a.push_back(mk(1100, 400, 0, 0, 'h000, 0, 0, 0, 0, 0));
        tab_a.push_back(mk(500, 257, 0, 0, 'h000, 0, 0, 0, 0, 0));
        tab_a.push_back(mk(500, 800, 0, 0, 'h000, 0, 0, 0, 0, 0));
        tab_a.push_back(mk(100, 100, 0, 0, 'h001, 0, 0, 0, 0, 0));
        tab_a.push_back(mk(100, 100, 1, 0, 'h001, 'h001, 0, 0, 0, 0));

        // Illegal clicks, X win, clicks in OVER, new_game, then a full draw.
        tab_b.push_back(mk(100, 100, 0, 0, 'h001, 'h001, 0, 1, 0, 0));
        tab_b.push_back(mk(100, 100, 1, 0, 'h001, 'h001, 0, 1, 0, 0));
        tab_b.push_back(mk(342, 100, 0, 0, 'h000, 'h001, 0, 1, 0, 0));
        tab_b.push_back(mk(342, 100, 1, 0, 'h000, 'h001, 0, 1, 0, 0));
        tab_b.push_back(mv(3, 0, 'h001, 'h000, 1, 0, 0));
        tab_b.push_back(mv(3, 1, 'h009, 'h008, 1, 0, 0));
        tab_b.push_back(mv(3, 0, 'h009, 'h008, 0, 0, 0));
        tab_b.push_back(mv(1, 1, 'h00B, 'h008, 0, 0, 0));
        tab_b.push_back(mv(1, 0, 'h00B, 'h008, 1, 0, 0));
        tab_b.push_back(mv(4, 1, 'h01B, 'h018, 1, 0, 0));
        tab_b.push_back(mv(4, 0, 'h01B, 'h018, 0, 0, 0));
        tab_b.push_back(mv(2, 1, 'h01F, 'h018, 0, 0, 0));
        tab_b.push_back(mv(2, 0, 'h01F, 'h018, 0, 1, 1));
        tab_b.push_back(mv(5, 1, 'h01F, 'h018, 0, 1, 1));
        tab_b.push_back(mv(5, 0, 'h01F, 'h018, 0, 1, 1));
        tab_b.push_back(mk(800, 400, 0, 1, 'h020, 0, 0, 0, 0, 0));
        tab_b.push_back(mv(0, 1, 'h001, 'h000, 0, 0, 0));
        tab_b.push_back(mv(0, 0, 'h001, 'h000, 1, 0, 0));
        tab_b.push_back(mv(1, 1, 'h003, 'h002, 1, 0, 0));
        tab_b.push_back(mv(1, 0, 'h003, 'h002, 0, 0, 0));
        tab_b.push_back(mv(2, 1, 'h007, 'h002, 0, 0, 0));
        tab_b.push_back(mv(2, 0, 'h007, 'h002, 1, 0, 0));
        tab_b.push_back(mv(4, 1, 'h017, 'h012, 1, 0, 0));
        tab_b.push_back(mv(4, 0, 'h017, 'h012, 0, 0, 0));
        tab_b.push_back(mv(3, 1, 'h01F, 'h012, 0, 0, 0));
        tab_b.push_back(mv(3, 0, 'h01F, 'h012, 1, 0, 0));
        tab_b.push_back(mv(5, 1, 'h03F, 'h032, 1, 0, 0));
        tab_b.push_back(mv(5, 0, 'h03F, 'h032, 0, 0, 0));
        tab_b.push_back(mv(7, 1, 'h0BF, 'h032, 0, 0, 0));
        tab_b.push_back(mv(7, 0, 'h0BF, 'h032, 1, 0, 0));
        tab_b.push_back(mv(6, 1, 'h0FF, 'h072, 1, 0, 0));
        tab_b.push_back(mv(6, 0, 'h0FF, 'h072, 0, 0, 0));
        tab_b.push_back(mv(8, 1, 'h1FF, 'h072, 0, 0, 0));
        tab_b.push_back(mv(8, 0, 'h1FF, 'h072, 0, 3, 1));
        tab_b.push_back(mv(8, 1, 'h1FF, 'h072, 0, 3, 1));

        #12;
        check_all("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge pclk);
        rst = 1'b0;

        for (int i = 0; i < tab_a.size(); i++) begin
            step($sformatf("a%0d", i), tab_a[i]);
        end

        // Holding the button must not register another move; the turn flips once.
        for (int i = 0; i < 50; i++) begin
            step($sformatf("hold%0d", i), mk(100, 100, 1, 0, 'h001, 'h001, 0, 1, 0, 0));
        end

        for (int i = 0; i < tab_b.size(); i++) begin
            step($sformatf("b%0d", i), tab_b[i]);
        end

        // new_game while OVER, then a legal click that leaves the FSM in CHECK.
        step("ng_over", mk(800, 600, 0, 1, 'h100, 0, 0, 0, 0, 0));
        step("pre_rst_move", mv(4, 1, 'h010, 'h000, 0, 0, 0));

        // Asynchronous reset between clock edges during CHECK.
        #2;
        rst = 1'b1;
        bif.mouse_left = 1'b0;
        #1;
        check_all("async_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge pclk);
        rst = 1'b0;

        step("post_rst_idle", mv(4, 0, 'h000, 'h000, 0, 0, 0));
        step("post_rst_move", mv(4, 1, 'h010, 'h000, 0, 0, 0));
        step("post_rst_turn", mv(4, 0, 'h010, 'h000, 1, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
